// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling defaults, mid-bit sample ticks and FSM encoding.
// Used by both the receive and transmit sides.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS      = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    // Three votes are taken around the bit centre; the decision uses the last one.
    function automatic int unsigned sample_lo(input int unsigned os);
        return os / 2 - 1;
    endfunction

    function automatic int unsigned sample_mid(input int unsigned os);
        return os / 2;
    endfunction

    function automatic int unsigned sample_hi(input int unsigned os);
        return os / 2 + 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to the line idle level (1).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_mod.sv
// Oversampling UART receiver: 8N1 frames, majority-vote bit decisions, single-byte
// holding register with framing-error and sticky overrun flags.
module rx_mod
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bclk,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       rx_rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       rts
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] T_LO   = CW'(sample_lo(OVERSAMPLE));
    localparam logic [CW-1:0] T_MID  = CW'(sample_mid(OVERSAMPLE));
    localparam logic [CW-1:0] T_HI   = CW'(sample_hi(OVERSAMPLE));
    localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);

    uart_state_e   state_q, state_n;
    logic          rxd_s, rxd_d;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          s_lo, s_mid;
    logic          maj, decide, wrap, fall, load;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign decide = bclk && (cnt == T_HI);
    assign wrap   = bclk && (cnt == T_LAST);
    assign fall   = rxd_d & ~rxd_s;
    assign maj    = (s_lo & s_mid) | (s_lo & rxd_s) | (s_mid & rxd_s);
    assign rts    = ~rx_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE:  if (fall) state_n = START;
            START: begin
                if (decide && maj) state_n = IDLE;
                else if (wrap)     state_n = DATA;
            end
            DATA:  if (wrap && bit_cnt == 4'(DATA_BITS)) state_n = STOP;
            STOP:  begin
                if (decide) begin
                    load    = 1'b1;
                    state_n = maj ? IDLE : BREAK;
                end
            end
            BREAK: if (rxd_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_d   <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            s_lo    <= 1'b1;
            s_mid   <= 1'b1;
        end else begin
            rxd_d <= rxd_s;
            if (state_q == IDLE || state_q == BREAK) cnt <= '0;
            else if (bclk)                           cnt <= (cnt == T_LAST) ? '0 : cnt + 1'b1;
            if (bclk && cnt == T_LO)  s_lo  <= rxd_s;
            if (bclk && cnt == T_MID) s_mid <= rxd_s;
            if (state_q == START) begin
                bit_cnt <= '0;
            end else if (state_q == DATA && decide) begin
                shreg   <= {maj, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // A pop in the same cycle as a stop decision frees the register for the new byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout      <= '0;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            if (!rx_rdy || rd) begin
                dout      <= shreg;
                frame_err <= ~maj;
                rx_rdy    <= 1'b1;
                overrun   <= 1'b0;
            end else begin
                overrun   <= 1'b1;
            end
        end else if (rd && rx_rdy) begin
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: doc/rx_mod.md
RX_MOD -- requirements
Module: rx_mod

Interface
REQ-001 Parameter OVERSAMPLE, default 16, bclk ticks per bit period.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 bclk  input  1  oversample tick; one-clk-wide pulse at OVERSAMPLE x baud rate.
REQ-005 rxd  input  1  serial line; asynchronous to clk, idle high.
REQ-006 rd  input  1  consumer acknowledge; a high cycle pops the holding register.
REQ-007 dout  output  8  received byte.
REQ-008 rx_rdy  output  1  high while dout holds an unread byte.
REQ-009 frame_err  output  1  stop bit of the byte in dout sampled low.
REQ-010 overrun  output  1  sticky flag: one or more bytes were lost while rx_rdy was high.
REQ-011 rts  output  1  equals ~rx_rdy; feeds the far-end transmitter's cts.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer before any use; this adds 2 clk of latency.
REQ-013 The frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-015 A per-bit tick counter SHALL count 0..OVERSAMPLE-1 and advance only on bclk.
REQ-016 IDLE: a synchronized 1->0 transition SHALL clear the tick counter and enter START.
REQ-017 Each bit SHALL be decided by majority vote of the samples at ticks 7, 8 and 9 (OVERSAMPLE/2-1 .. OVERSAMPLE/2+1); the decision is taken at tick 9.
REQ-018 START: a majority of 1 SHALL be treated as a glitch and return the FSM to IDLE with no output change.
REQ-019 START: a majority of 0 SHALL enter DATA when the counter wraps, with bit index 0.
REQ-020 DATA: the shift register SHALL collect 8 decided bits LSB first, then enter STOP.
REQ-021 STOP, stop bit 1: at tick 9 the FSM SHALL return to IDLE immediately, so back-to-back frames are accepted.
REQ-022 STOP, stop bit 0: the FSM SHALL enter BREAK and remain there until the synchronized rxd is 1, then enter IDLE.
REQ-023 Load rule at the stop decision, holding register empty or rd high in the same cycle: the byte SHALL be loaded into dout, frame_err SHALL take the value ~stop, and rx_rdy SHALL be 1 on the next clk.
REQ-024 Load rule at the stop decision, rx_rdy=1 and rd low: the new byte SHALL be discarded, dout and frame_err SHALL hold, and overrun SHALL be set.
REQ-025 rd with rx_rdy=1 and no simultaneous load SHALL clear rx_rdy, frame_err and overrun on the next clk.
REQ-026 rd with rx_rdy=0 SHALL have no effect.
REQ-027 dout SHALL remain stable while rx_rdy=1.
REQ-028 Latency from the stop-bit decision tick to rx_rdy high SHALL be 1 clk.

Reset
REQ-029 Asserting rst low SHALL immediately force: FSM to IDLE, counters to 0, dout=8'h00, rx_rdy=0, frame_err=0, overrun=0, rts=1, and both synchronizer flops to 1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame.
REQ-031 After reset, reception SHALL resume only on a fresh 1->0 edge.

Structure
REQ-032 OVERSAMPLE default, sample tick indices and the FSM state encoding SHALL live in shared package uart_pkg, which tx-side blocks also use.
REQ-033 The synchronizer SHALL be a separate sub-module sync2 (1-bit, reset value 1).
REQ-034 All other logic SHALL be inline in rx_mod.

Verification (bclk tied high, so 1 bit = 16 clk)
REQ-035 Frame 0xA5 with stop=1 -> dout=0xA5, rx_rdy=1, frame_err=0, rts=0; then a 1-clk rd pulse -> rx_rdy=0, rts=1.
REQ-036 rxd low for 4 clk then high -> FSM back in IDLE; rx_rdy stays 0 and dout is unchanged.
REQ-037 Frame 0x3C with stop=0, then rxd held low for 40 bit times -> dout=0x3C, frame_err=1, no further bytes; rxd high then frame 0x81 -> 0x81 accepted after rd.
REQ-038 Frames 0x11 then 0x22 back-to-back with no rd -> dout=0x11, overrun=1; rd -> rx_rdy, overrun and frame_err all 0.
REQ-039 rd asserted on the stop-decision cycle of 0x22 while 0x11 is held -> dout=0x22, rx_rdy stays 1, overrun=0.
REQ-040 rst pulsed low mid-DATA of 0xFF -> all outputs at their reset values; next frame 0x5A -> dout=0x5A, frame_err=0.
